// File: rtl/ifu2exu_ibuf.sv
// ifu2exu_ibuf: instruction buffer (FIFO of {IR, PC}) decoupling fetch from execute.
// Ports:
//   clk, rst_n          - core clock, asynchronous active-low reset
//   ibuf_i_ifu_valid    - fetch presents IR/PC; ibuf_o_ifu_ready - buffer not full
//   ibuf_i_ir/ibuf_i_pc - fetched instruction word and its PC
//   ibuf_i_flush        - pipeline flush, empties the buffer at the edge
//   ibuf_o_exu_valid    - head valid toward EXU; ibuf_i_exu_ready - EXU accepts head
//   ibuf_o_ir/ibuf_o_pc - head entry (zero when empty); ibuf_o_rv32 - head is 32-bit
//   ibuf_o_empty/full/count - occupancy status
module ifu2exu_ibuf #(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int PTR_W   = 1,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ibuf_i_ifu_valid,
    output logic               ibuf_o_ifu_ready,
    input  logic [XLEN-1:0]    ibuf_i_ir,
    input  logic [PC_SIZE-1:0] ibuf_i_pc,
    input  logic               ibuf_i_flush,
    output logic               ibuf_o_exu_valid,
    input  logic               ibuf_i_exu_ready,
    output logic [XLEN-1:0]    ibuf_o_ir,
    output logic [PC_SIZE-1:0] ibuf_o_pc,
    output logic               ibuf_o_rv32,
    output logic               ibuf_o_empty,
    output logic               ibuf_o_full,
    output logic [CNT_W-1:0]   ibuf_o_count
);
    logic [XLEN-1:0]    r_ir [DEPTH];
    logic [PC_SIZE-1:0] r_pc [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_empty, w_full, w_push, w_pop;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == CNT_W'(DEPTH);
    // ready depends only on registered occupancy, so a pop cannot make room in the same cycle
    assign ibuf_o_ifu_ready = ~w_full;
    assign w_push = ibuf_i_ifu_valid & ~w_full & ~ibuf_i_flush;
    // flush masks valid so EXU never takes a stale entry; this also blocks pop during flush
    assign ibuf_o_exu_valid = ~w_empty & ~ibuf_i_flush;
    assign w_pop = ibuf_o_exu_valid & ibuf_i_exu_ready;

    assign ibuf_o_ir    = w_empty ? '0 : r_ir[r_rd_ptr];
    assign ibuf_o_pc    = w_empty ? '0 : r_pc[r_rd_ptr];
    assign ibuf_o_rv32  = ~w_empty & (ibuf_o_ir[1:0] == 2'b11);
    assign ibuf_o_empty = w_empty;
    assign ibuf_o_full  = w_full;
    assign ibuf_o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ir[i] <= '0;
                r_pc[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ibuf_i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_ir[r_wr_ptr] <= ibuf_i_ir;
                r_pc[r_wr_ptr] <= ibuf_i_pc;
                r_wr_ptr       <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop)
                r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_ifu2exu_ibuf.sv
// tb_ifu2exu_ibuf: scoreboard bench for ifu2exu_ibuf against a queue reference model.
module tb_ifu2exu_ibuf;
    localparam int DEPTH = 2;
    logic        clk = 0, rst_n = 0;
    logic        ifu_valid = 0, ifu_ready, flush = 0, exu_valid, exu_ready = 0;
    logic [31:0] ir_i = 0, pc_i = 0, ir_o, pc_o;
    logic        rv32, empty, full;
    logic [1:0]  count;
    logic [63:0] exp_q[$];
    logic [63:0] hd;
    int          occ, m_occ, errors = 0, checks = 0;

    ifu2exu_ibuf dut (
        .clk(clk), .rst_n(rst_n),
        .ibuf_i_ifu_valid(ifu_valid), .ibuf_o_ifu_ready(ifu_ready),
        .ibuf_i_ir(ir_i), .ibuf_i_pc(pc_i), .ibuf_i_flush(flush),
        .ibuf_o_exu_valid(exu_valid), .ibuf_i_exu_ready(exu_ready),
        .ibuf_o_ir(ir_o), .ibuf_o_pc(pc_o), .ibuf_o_rv32(rv32),
        .ibuf_o_empty(empty), .ibuf_o_full(full), .ibuf_o_count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: compares DUT state with the model and retires the head on a handshake.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            occ   = exp_q.size();
            m_occ = occ;
            hd    = occ > 0 ? exp_q[0] : 64'd0;
            chk("count", 64'(count), 64'(occ));
            chk("empty", 64'(empty), 64'(occ == 0));
            chk("full", 64'(full), 64'(occ == DEPTH));
            chk("ifu_ready", 64'(ifu_ready), 64'(occ < DEPTH));
            chk("exu_valid", 64'(exu_valid), 64'(occ > 0 && !flush));
            chk("ir", 64'(ir_o), 64'(hd[63:32]));
            chk("pc", 64'(pc_o), 64'(hd[31:0]));
            chk("rv32", 64'(rv32), 64'(occ > 0 && hd[33:32] == 2'b11));
            if (occ > 0 && !flush && exu_ready)
                void'(exp_q.pop_front());
        end
    end

    // Driver: issues one cycle of stimulus and pushes the expected entry if fetch is accepted.
    task automatic cyc(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                       input logic r, input logic f);
        @(negedge clk);
        ifu_valid = v; ir_i = ir; pc_i = pc; exu_ready = r; flush = f;
        #2;
        if (f)
            exp_q.delete();
        else if (v && m_occ < DEPTH)
            exp_q.push_back({ir, pc});
    endtask

    task automatic idle_inputs();
        ifu_valid = 0; exu_ready = 0; flush = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        // single push, no pop
        cyc(1, 32'h00500093, 32'h80000000, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        // fill to full, third offered while full, then drain
        cyc(1, 32'h00100093, 32'h80000000, 0, 0);
        cyc(1, 32'h00200093, 32'h80000004, 0, 0);
        cyc(1, 32'h00300093, 32'h80000008, 0, 0);
        cyc(1, 32'h00300093, 32'h80000008, 1, 0);
        cyc(1, 32'h00300093, 32'h80000008, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // streaming with pointer wrap
        for (int i = 0; i < 8; i++)
            cyc(1, 32'h00000013 | (i << 20), 32'(i * 4), 1, 0);
        cyc(0, 0, 0, 1, 0);
        // flush with two entries while both handshakes are offered
        cyc(1, 32'h11100093, 32'h80000010, 0, 0);
        cyc(1, 32'h22200093, 32'h80000014, 0, 0);
        cyc(1, 32'h33300093, 32'h80000018, 1, 1);
        cyc(1, 32'h44400093, 32'h80000100, 0, 0);
        cyc(0, 0, 0, 1, 0);
        // multi-cycle flush keeps buffer empty
        cyc(1, 32'h55500093, 32'h80000200, 1, 1);
        cyc(1, 32'h55500093, 32'h80000204, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // compressed vs 32-bit head
        cyc(1, 32'h00004501, 32'h80000300, 0, 0);
        cyc(1, 32'h00000013, 32'h80000302, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        // asynchronous reset with one entry buffered
        cyc(1, 32'h00700093, 32'h80000400, 0, 0);
        @(posedge clk);
        #1 idle_inputs();
        #1 rst_n = 0;
        #1;
        chk("async_rst exu_valid", 64'(exu_valid), 64'd0);
        chk("async_rst count", 64'(count), 64'd0);
        chk("async_rst ir", 64'(ir_o), 64'd0);
        chk("async_rst ifu_ready", 64'(ifu_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        cyc(1, 32'h00500093, 32'h80000000, 0, 0);
        cyc(0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r_ir;
            r_ir = $urandom;
            if ($urandom_range(0, 1) == 1) r_ir[1:0] = 2'b11;
            cyc($urandom_range(0, 9) < 7, r_ir, $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
